// File: rtl/bundler_ctrl.sv
// rtl/bundler_ctrl.sv - sequences one bundling pass over DIM-bit HVs through a PAR_BITS-wide bundler_bits datapath
module bundler_ctrl #(
   parameter int NUM_HVS  = 5,
   parameter int PAR_BITS = 2,
   parameter int DIM      = 8,
   parameter int TIMEOUT  = 16
) (
   input  logic                             clk,
   input  logic                             nrst,
   input  logic                             start,
   input  logic [NUM_HVS-1:0][DIM-1:0]      hvs,
   input  logic [DIM-1:0]                   tie_hv,
   output logic                             busy,
   output logic                             done,
   output logic                             err,
   output logic [DIM-1:0]                   result_hv,
   output logic                             bnd_en,
   output logic [NUM_HVS-1:0][PAR_BITS-1:0] bnd_bits,
   output logic [PAR_BITS-1:0]              bnd_tie_bits,
   input  logic                             bnd_done,
   input  logic [PAR_BITS-1:0]              bnd_out_bits
);
   localparam int NUM_CHUNKS = DIM / PAR_BITS;
   localparam int CIDX_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(NUM_CHUNKS - 1);
   // Last WAIT cycle index: the timeout FINISH lands TIMEOUT cycles after ISSUE.
   localparam logic [15:0] LAST_WAIT = (TIMEOUT >= 2) ? 16'(TIMEOUT - 2) : 16'd0;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

   state_t            state_q, state_d;
   logic [CIDX_W-1:0] chunk_idx_q, chunk_idx_d;
   logic [15:0]       wait_cnt_q, wait_cnt_d;
   logic              err_q, err_d;
   logic [DIM-1:0]    result_q, result_d;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= S_IDLE;
         chunk_idx_q <= '0;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         chunk_idx_q <= chunk_idx_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
         result_q    <= result_d;
      end
   end

   // Chunk select follows the registered index so the datapath inputs hold through WAIT.
   always_comb begin
      bnd_bits     = '0;
      bnd_tie_bits = '0;
      for (int c = 0; c < NUM_CHUNKS; c++) begin
         if (chunk_idx_q == CIDX_W'(c)) begin
            for (int h = 0; h < NUM_HVS; h++) begin
               bnd_bits[h] = hvs[h][c*PAR_BITS +: PAR_BITS];
            end
            bnd_tie_bits = tie_hv[c*PAR_BITS +: PAR_BITS];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      chunk_idx_d = chunk_idx_q;
      wait_cnt_d  = wait_cnt_q;
      err_d       = err_q;
      result_d    = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_ISSUE;
               chunk_idx_d = '0;
               err_d       = 1'b0;
               result_d    = '0;
            end
         end
         S_ISSUE: begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (bnd_done) begin
               for (int c = 0; c < NUM_CHUNKS; c++) begin
                  if (chunk_idx_q == CIDX_W'(c)) begin
                     result_d[c*PAR_BITS +: PAR_BITS] = bnd_out_bits;
                  end
               end
               if (chunk_idx_q == LAST_CHUNK) begin
                  state_d = S_FINISH;
               end else begin
                  chunk_idx_d = chunk_idx_q + 1'b1;
                  state_d     = S_ISSUE;
               end
            end else if (wait_cnt_q == LAST_WAIT) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         S_FINISH: begin
            chunk_idx_d = '0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FINISH);
   assign bnd_en    = (state_q == S_ISSUE);
   assign err       = err_q;
   assign result_hv = result_q;
endmodule
